stage_f: RTL and testbench
==========================

# stage_f

Fetch stage of the five-stage MIPS pipeline; sits directly upstream of the decode-stage register. Owns the program counter and selects the next PC from sequential, branch, jump-register, ERET and exception-entry sources. Drives the instruction-memory address, flags fetch address errors (AdEL) and marks delay-slot instructions. Also keeps a retired-fetch counter for performance monitoring.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset
- HANDLER_PC, 32'h0000_4180, exception entry PC
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- stall  in  1  hold PC; same stall as the decode register
- req  in  1  exception/interrupt taken this cycle; redirect to HANDLER_PC
- flush  in  1  ERET in decode; redirect to jumpto
- jumpto  in  32  ERET target (EPC)
- d_is_jump  in  1  instruction in decode is a branch or jump
- br_taken  in  1  branch/jump in decode is taken
- br_target  in  32  branch/jump target from decode
- pc_out  out  32  current fetch PC; also the instruction-memory address
- exc_out  out  5  fetch exception code: 0 = none, 4 = AdEL
- slot_out  out  1  fetched instruction is a delay slot
- fetch_cnt  out  32  number of PC advances since reset

## Operation
- Current fetch PC lives in register pc.
- pc_out equals pc, combinationally. The instruction memory reads synchronously. The instruction arrives at the decode stage in the following cycle.
- exc_out is combinational from pc:
  - 5'd4 if pc[1:0] != 0, or pc < TEXT_LO, or pc > TEXT_HI (unsigned compare).
  - Otherwise 0.
- slot_out is combinational: d_is_jump & ~flush.
- Next-PC priority, highest first, evaluated each rising edge:
  1. req: pc <= HANDLER_PC
  2. stall: pc held
  3. flush: pc <= jumpto
  4. br_taken: pc <= br_target
  5. default: pc <= pc + 4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0)
- br_taken is ignored unless d_is_jump = 1.
- br_target and jumpto are used unchecked. A misaligned or out-of-range target takes effect and raises exc_out = 4 in the following cycle.
- fetch_cnt:
  - Increments by 1 on every edge where pc is loaded, i.e. all cases except stall and reset.
  - Wraps modulo 2^32.
  - Not cleared by req or flush.
- The stage never suppresses an instruction. On exc_out != 0, downstream stages squash the instruction and raise AdEL.

## Timing
- While rst = 1, asynchronously and immediately:
  - pc = RESET_PC, fetch_cnt = 0.
  - Hence pc_out = 32'h3000, exc_out = 0, slot_out = d_is_jump & ~flush.
- After rst deasserts, the first edge with no stall advances to 32'h3004.
- Redirect latency is one cycle for req, flush and br_taken: the new PC appears on pc_out right after the edge where the request is sampled.
- Taken branch: the instruction fetched in the cycle the branch sits in decode is the delay slot (slot_out = 1). The target is fetched in the next cycle.
- Simultaneous events resolve strictly by the priority list:
  - req + stall: redirect to HANDLER_PC.
  - stall + br_taken: PC held; the branch re-presents next cycle because decode is also held.
  - flush + br_taken: jumpto wins.
- Reset asserted mid-operation overrides everything without waiting for a clock edge.

## Test plan
- Reset then 3 unstalled cycles -> pc_out 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt 0, 1, 2, 3; exc_out 0 throughout.
- d_is_jump=1, br_taken=1, br_target=0x3100 at pc 0x3010 -> slot_out=1 that cycle; next pc_out 0x3100, fetch_cnt +1.
- stall=1 for 2 cycles with br_taken=1 -> pc_out held and fetch_cnt unchanged; on the first unstalled edge pc_out = br_target.
- req=1 together with stall=1 and flush=1 -> next pc_out 0x4180, exc_out 0.
- flush=1, jumpto=0x3002, d_is_jump=1 -> slot_out=0; next pc_out 0x3002 with exc_out=4. Repeat with jumpto=0x2FFC -> exc_out=4; with jumpto=0x6FFC -> exc_out=0, then 0x7000 -> exc_out=4.
- Assert rst between clock edges mid-run at pc 0x3040 -> pc_out becomes 0x3000 and fetch_cnt 0 before the next edge.

Source files
------------

// File: rtl/stage_f_if.sv
// stage_f_if: fetch-stage control/redirect inputs and fetch outputs.
// The master side (decode/exception logic) drives the control signals;
// the slave side (stage_f) drives the fetch PC and its status.
interface stage_f_if;
    logic        stall;
    logic        req;
    logic        flush;
    logic [31:0] jumpto;
    logic        d_is_jump;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_out;
    logic [4:0]  exc_out;
    logic        slot_out;
    logic [31:0] fetch_cnt;

    modport master (
        output stall, req, flush, jumpto, d_is_jump, br_taken, br_target,
        input  pc_out, exc_out, slot_out, fetch_cnt
    );

    modport slave (
        input  stall, req, flush, jumpto, d_is_jump, br_taken, br_target,
        output pc_out, exc_out, slot_out, fetch_cnt
    );
endinterface

// File: rtl/stage_f.sv
// stage_f: MIPS fetch stage. Owns the program counter, picks the next PC
// from exception entry, ERET, branch/jump or sequential sources, flags
// fetch address errors (AdEL) and marks delay-slot fetches. Also counts
// every PC load for performance monitoring.
module stage_f #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
    input  logic       clk,
    input  logic       rst,
    stage_f_if.slave   bus
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_r;
    logic [31:0] fetch_cnt_r;
    logic [31:0] pc_next_s;
    logic        pc_load_s;
    logic [4:0]  exc_s;

    // A fetch address is illegal when misaligned or outside the text segment.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);
    endfunction

    // Next-PC selection: exception entry beats stall, stall beats ERET,
    // ERET beats a taken branch, otherwise fetch sequentially (32-bit wrap).
    always_comb begin
        pc_next_s = pc_r + 32'd4;
        pc_load_s = 1'b1;
        if (bus.req) begin
            pc_next_s = HANDLER_PC;
        end else if (bus.stall) begin
            pc_next_s = pc_r;
            pc_load_s = 1'b0;
        end else if (bus.flush) begin
            pc_next_s = bus.jumpto;
        end else if (bus.d_is_jump && bus.br_taken) begin
            pc_next_s = bus.br_target;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // PC and fetch counter; reset takes effect immediately, not at an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            fetch_cnt_r <= 32'd0;
        end else begin
            pc_r <= pc_next_s;
            if (pc_load_s) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end else begin
                fetch_cnt_r <= fetch_cnt_r;
            end
        end
    end

    // AdEL is reported on the fetch itself; downstream squashes the instruction.
    always_comb begin
        exc_s = EXC_NONE;
        if (fetch_addr_bad(pc_r)) begin
            exc_s = EXC_ADEL;
        end else begin
            exc_s = EXC_NONE;
        end
    end

    assign bus.pc_out    = pc_r;
    assign bus.exc_out   = exc_s;
    assign bus.slot_out  = bus.d_is_jump & ~bus.flush;
    assign bus.fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_stage_f.sv
// tb_stage_f: table-driven check of stage_f with a scoreboard queue of
// post-edge expectations, plus a hand-written asynchronous mid-run reset.
module tb_stage_f;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    stage_f_if bus_if ();

    stage_f dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic        flush;
        logic [31:0] jumpto;
        logic        dj;
        logic        bt;
        logic [31:0] tgt;
        logic        slot;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs [24];
    exp_t sbq [$];

    function automatic vec_t mk(input logic s, input logic r, input logic f,
                                input logic [31:0] j, input logic dj, input logic bt,
                                input logic [31:0] t, input logic slot,
                                input logic [31:0] pc, input logic [4:0] exc,
                                input logic [31:0] cnt);
        vec_t v;
        v.stall = s; v.req = r; v.flush = f; v.jumpto = j;
        v.dj = dj; v.bt = bt; v.tgt = t; v.slot = slot;
        v.pc = pc; v.exc = exc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus_if.stall     = v.stall;
        bus_if.req       = v.req;
        bus_if.flush     = v.flush;
        bus_if.jumpto    = v.jumpto;
        bus_if.d_is_jump = v.dj;
        bus_if.br_taken  = v.bt;
        bus_if.br_target = v.tgt;
    endtask

    task automatic check_pop();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got 0 entries expected >=1");
        end else begin
            e = sbq.pop_front();
            chk($sformatf("pc[%0d]", e.idx), bus_if.pc_out, e.pc);
            chk($sformatf("exc[%0d]", e.idx), {27'd0, bus_if.exc_out}, {27'd0, e.exc});
            chk($sformatf("cnt[%0d]", e.idx), bus_if.fetch_cnt, e.cnt);
        end
    endtask

    initial begin
        vec_t idle;
        exp_t e;
        total = 0;
        bad   = 0;

        //          stl  req  fl   jumpto        dj   bt   target        slot pc            exc   cnt
        vecs[0]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_3004,5'd0,32'd1);
        vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_3008,5'd0,32'd2);
        vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_300C,5'd0,32'd3);
        vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_3010,5'd0,32'd4);
        vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_3100,1'b1,32'h0000_3100,5'd0,32'd5);
        vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_3200,1'b1,32'h0000_3100,5'd0,32'd5);
        vecs[6]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_3200,1'b1,32'h0000_3100,5'd0,32'd5);
        vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_3200,1'b1,32'h0000_3200,5'd0,32'd6);
        vecs[8]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_3300,1'b0,32'h0000_3204,5'd0,32'd7);
        vecs[9]  = mk(1'b1,1'b1,1'b1,32'h0000_3500,1'b1,1'b0,32'h0,        1'b0,32'h0000_4180,5'd0,32'd8);
        vecs[10] = mk(1'b0,1'b0,1'b1,32'h0000_3002,1'b1,1'b1,32'h0000_3600,1'b0,32'h0000_3002,5'd4,32'd9);
        vecs[11] = mk(1'b0,1'b0,1'b1,32'h0000_2FFC,1'b0,1'b0,32'h0,        1'b0,32'h0000_2FFC,5'd4,32'd10);
        vecs[12] = mk(1'b0,1'b0,1'b1,32'h0000_6FFC,1'b0,1'b0,32'h0,        1'b0,32'h0000_6FFC,5'd0,32'd11);
        vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_7000,5'd4,32'd12);
        vecs[14] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_4180,5'd0,32'd13);
        vecs[15] = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_4180,5'd0,32'd14);
        vecs[16] = mk(1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0,        1'b0,32'hFFFF_FFFC,5'd4,32'd15);
        vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_0000,5'd4,32'd16);
        vecs[18] = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h0000_0000,5'd4,32'd16);
        vecs[19] = mk(1'b0,1'b0,1'b1,32'h0000_3030,1'b0,1'b0,32'h0,        1'b0,32'h0000_3030,5'd0,32'd17);
        vecs[20] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_3034,5'd0,32'd18);
        vecs[21] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_3038,5'd0,32'd19);
        vecs[22] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_303C,5'd0,32'd20);
        vecs[23] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0000_3040,5'd0,32'd21);
        idle = vecs[0];

        // Reset held across a couple of edges.
        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", bus_if.pc_out, 32'h0000_3000);
        chk("rst_exc", {27'd0, bus_if.exc_out}, 32'd0);
        chk("rst_cnt", bus_if.fetch_cnt, 32'd0);
        chk("rst_slot", {31'd0, bus_if.slot_out}, 32'd0);
        rst = 1'b0;

        // Table-driven vectors; each drives one edge, expectation queued.
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("slot[%0d]", i), {31'd0, bus_if.slot_out}, {31'd0, vecs[i].slot});
            e.idx = i; e.pc = vecs[i].pc; e.exc = vecs[i].exc; e.cnt = vecs[i].cnt;
            sbq.push_back(e);
            @(posedge clk);
            @(negedge clk);
            check_pop();
        end

        // Asynchronous reset between edges at pc 0x3040.
        drive(idle);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", bus_if.pc_out, 32'h0000_3000);
        chk("arst_cnt", bus_if.fetch_cnt, 32'd0);
        chk("arst_exc", {27'd0, bus_if.exc_out}, 32'd0);
        #1;
        rst = 1'b0;
        e.idx = 100; e.pc = 32'h0000_3004; e.exc = 5'd0; e.cnt = 32'd1;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_pop();

        chk("sb_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
